// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite SRAM responder with byte lanes, wait states and ERROR responses
module ahb_sram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready_o,
  output logic                  hresp
);

  localparam int NLANES = DATA_WIDTH / 8;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Registered address-phase information of the data phase in flight
  logic              pend;
  logic              p_write;
  logic [IW-1:0]     p_idx;
  logic [NLANES-1:0] p_lanes;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  bad;
  logic                  commit;
  logic [ADDR_WIDTH-3:0] word_addr;
  logic [IW-1:0]         idx;
  logic [NLANES-1:0]     lanes;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  // htrans[0] only distinguishes SEQ from NONSEQ and BUSY from IDLE; neither matters here
  logic unused_trans;
  assign unused_trans = htrans[0];

  // Address-phase decode: accept qualifier, error check and byte-lane selection
  always_comb begin
    accept    = hsel & htrans[1] & hready_o;
    word_addr = haddr[ADDR_WIDTH-1:2];
    idx       = word_addr[IW-1:0];
    bad       = (hsize > 3'd2)
              | ((hsize == 3'd1) & haddr[0])
              | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
              | (word_addr >= DEPTH_LIM);
    case (hsize)
      3'd0:    lanes = NLANES'(1) << haddr[1:0];
      3'd1:    lanes = haddr[1] ? NLANES'(4'b1100) : NLANES'(4'b0011);
      default: lanes = '1;
    endcase
  end

  // Write merge for the completing data phase, plus forwarding so a read accepted on the
  // same edge as a write to the same word sees the new bytes
  always_comb begin
    commit  = hready_o & pend & p_write;
    wr_word = mem[p_idx];
    for (int i = 0; i < NLANES; i++) begin
      if (p_lanes[i]) wr_word[8*i +: 8] = hwdata[8*i +: 8];
    end
    rd_word = (commit && (p_idx == idx)) ? wr_word : mem[idx];
  end

  // Response outputs decode straight from the state so reset forces them immediately
  always_comb begin
    hready_o = (state == S_IDLE) || (state == S_ERR2);
    hresp    = (state == S_ERR1) || (state == S_ERR2);
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
        if (accept) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WS != 4'd0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = S_IDLE;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending transfer capture and read-data register; only advances while hready_o is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= 1'b0;
      p_write <= 1'b0;
      p_idx   <= '0;
      p_lanes <= '0;
      hrdata  <= '0;
    end else if (hready_o) begin
      pend <= accept & ~bad;
      if (accept) begin
        p_write <= hwrite;
        p_idx   <= idx;
        p_lanes <= lanes;
        if (!hwrite) hrdata <= bad ? '0 : rd_word;
      end
    end
  end

  // SRAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int i = 0; i < NLANES; i++) begin
        if (p_lanes[i]) mem[p_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - directed bench for ahb_sram_responder (0 and 3 wait states)
module tb_ahb_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = '0;

  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_sram_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(rdata0), .hready_o(rdy0), .hresp(resp0)
  );

  ahb_sram_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(rdata3), .hready_o(rdy3), .hresp(resp3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = w;
    haddr  = a;
    hsize  = sz;
    hwdata = wd;
  endtask

  task automatic drive_idle(input logic [31:0] wd);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  // Counts low-hready cycles of dut3; returns at the negedge of the completing cycle
  task automatic wait3(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy3 === 1'b1 || n >= 20) break;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
    checks++; if (resp0 !== 1'b0)  begin errors++; $display("FAIL reset_resp0 got=%b exp=0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (rdy3 !== 1'b1)   begin errors++; $display("FAIL reset_rdy3 got=%b exp=1", rdy3); end
    checks++; if (resp3 !== 1'b0)  begin errors++; $display("FAIL reset_resp3 got=%b exp=0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h10, 3'd2, 32'h0);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_rdy_a got=%b exp=1", rdy0); end
    tick();
    drive(1'b0, 32'h10, 3'd2, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_phase got rdy=%b resp=%b exp rdy=1 resp=0", rdy0, resp0); end
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL b2b_rd_phase got rdy=%b resp=%b exp rdy=1 resp=0", rdy0, resp0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got=%h exp=deadbeef", rdata0); end
    tick();
    drive(1'b0, 32'h10, 3'd2, 32'h0);
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_reread got=%h exp=deadbeef", rdata0); end
    tick();
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 32'h0, 3'd2, 32'h0);
    tick();
    drive(1'b1, 32'h3, 3'd0, 32'h0);
    tick();
    drive(1'b1, 32'h0, 3'd1, 32'hAAAAAAAA);
    tick();
    drive(1'b0, 32'h0, 3'd2, 32'hFFFF1234);
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdata0 !== 32'hAA001234) begin errors++; $display("FAIL lanes_fwd got=%h exp=aa001234", rdata0); end
    tick();
    drive(1'b0, 32'h0, 3'd2, 32'h0);
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdata0 !== 32'hAA001234) begin errors++; $display("FAIL lanes_mem got=%h exp=aa001234", rdata0); end
    tick();
  endtask

  task automatic test_hazard();
    drive(1'b1, 32'h20, 3'd2, 32'h0);
    tick();
    drive(1'b1, 32'h20, 3'd2, 32'h55555555);
    tick();
    drive(1'b0, 32'h20, 3'd2, 32'h11223344);
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdata0 !== 32'h11223344) begin errors++; $display("FAIL hazard_rdata got=%h exp=11223344", rdata0); end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] ea [4];
    logic [2:0]  es [4];
    ea = '{32'h2, 32'h1, 32'h0, 32'h1000};
    es = '{3'd2, 3'd1, 3'd3, 3'd2};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ea[k], es[k], 32'h0);
      tick();
      drive_idle(32'hFFFFFFFF);
      @(negedge clk);
      checks++; if (rdy0 !== 1'b0 || resp0 !== 1'b1) begin errors++; $display("FAIL err%0d_err1 got rdy=%b resp=%b exp rdy=0 resp=1", k, rdy0, resp0); end
      tick();
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin errors++; $display("FAIL err%0d_err2 got rdy=%b resp=%b exp rdy=1 resp=1", k, rdy0, resp0); end
      tick();
      @(negedge clk);
      checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL err%0d_after got rdy=%b resp=%b exp rdy=1 resp=0", k, rdy0, resp0); end
    end
    drive(1'b0, 32'h0, 3'd2, 32'h0);
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdata0 !== 32'hAA001234) begin errors++; $display("FAIL err_unchanged got=%h exp=aa001234", rdata0); end
    tick();
    drive(1'b0, 32'h1000, 3'd2, 32'h0);
    tick();
    drive_idle(32'h0);
    tick();
    drive(1'b0, 32'h10, 3'd2, 32'h0);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin errors++; $display("FAIL errrd_err2 got rdy=%b resp=%b exp rdy=1 resp=1", rdy0, resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL errrd_rdata got=%h exp=0", rdata0); end
    tick();
    drive_idle(32'h0);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("FAIL err2_pipe_resp got rdy=%b resp=%b exp rdy=1 resp=0", rdy0, resp0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL err2_pipe_rdata got=%h exp=deadbeef", rdata0); end
    tick();
  endtask

  task automatic test_wait_states();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 32'h40, 3'd2, 32'h0);
    tick();
    drive(1'b0, 32'h40, 3'd2, 32'hCAFEF00D);
    wait3(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws_write_waits got=%0d exp=3", n); end
    tick();
    drive(1'b1, 32'h44, 3'd2, 32'h0);
    wait3(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws_read_waits got=%0d exp=3", n); end
    checks++; if (rdata3 !== 32'hCAFEF00D || resp3 !== 1'b0) begin errors++; $display("FAIL ws_read_data got=%h resp=%b exp=cafef00d resp=0", rdata3, resp3); end
    tick();
    drive(1'b0, 32'h44, 3'd2, 32'h0BADF00D);
    wait3(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws_held_waits got=%0d exp=3", n); end
    tick();
    drive_idle(32'h0);
    wait3(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws_read2_waits got=%0d exp=3", n); end
    checks++; if (rdata3 !== 32'h0BADF00D) begin errors++; $display("FAIL ws_read2_data got=%h exp=0badf00d", rdata3); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    drive(1'b1, 32'h40, 3'd2, 32'h0);
    tick();
    drive_idle(32'h99999999);
    @(negedge clk);
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL rst_mid_inwait got=%b exp=0", rdy3); end
    reset = 1'b1;
    #1;
    checks++; if (rdy3 !== 1'b1 || resp3 !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got rdy=%b resp=%b exp rdy=1 resp=0", rdy3, resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata3); end
    tick();
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h40, 3'd2, 32'h0);
    tick();
    drive_idle(32'h0);
    wait3(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rst_after_waits got=%0d exp=3", n); end
    checks++; if (rdata3 !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_after_data got=%h exp=cafef00d", rdata3); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_hazard();
    test_errors();
    test_wait_states();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
